// File: rtl/two_bit_and_driver_pkg.sv
// Shared encodings and constants for the 2-bit AND stimulus/response driver.
// Holds FSM state codes, sweep sizes and the first_fail field layout.
package two_bit_and_driver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int NUM_VEC = 16;
  localparam int VEC_W   = 4;
  localparam int PASS_W  = 4;
  localparam int SC_W    = 4;

  // first_fail layout: {a[1:0], b[1:0], o[1:0]}
  localparam int FF_W     = 6;
  localparam int FF_A_LSB = 4;
  localparam int FF_B_LSB = 2;
  localparam int FF_O_LSB = 0;

  function automatic logic [FF_W-1:0] pack_fail(input logic [1:0] a,
                                                input logic [1:0] b,
                                                input logic [1:0] o);
    logic [FF_W-1:0] f;
    f = '0;
    f[FF_A_LSB +: 2] = a;
    f[FF_B_LSB +: 2] = b;
    f[FF_O_LSB +: 2] = o;
    return f;
  endfunction

endpackage

// File: rtl/two_bit_and_vec_gen.sv
// Operand-pair and pass counters for the sweep; last flags the final
// vector of the final pass.
module two_bit_and_vec_gen
  import two_bit_and_driver_pkg::*;
#(
  parameter int PASSES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             step,
  output logic [VEC_W-1:0] vec,
  output logic             last
);

  logic [VEC_W-1:0]  vec_q, vec_d;
  logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
  logic              vec_max;

  assign vec_max = (vec_q == VEC_W'(NUM_VEC - 1));

  always_comb begin
    vec_d      = vec_q;
    pass_cnt_d = pass_cnt_q;
    if (clear) begin
      vec_d      = '0;
      pass_cnt_d = '0;
    end else if (step) begin
      if (vec_max) begin
        vec_d      = '0;
        pass_cnt_d = pass_cnt_q + PASS_W'(1);
      end else begin
        vec_d = vec_q + VEC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec_q      <= '0;
      pass_cnt_q <= '0;
    end else begin
      vec_q      <= vec_d;
      pass_cnt_q <= pass_cnt_d;
    end
  end

  assign vec  = vec_q;
  assign last = vec_max && (pass_cnt_q == PASS_W'(PASSES - 1));

endmodule

// File: rtl/two_bit_and_driver.sv
// Drives all 16 operand pairs into a 2-bit AND, compares o against a & b
// and reports pass/fail, a saturating error count and the first failing vector.
module two_bit_and_driver
  import two_bit_and_driver_pkg::*;
#(
  parameter int SETTLE = 1,
  parameter int PASSES = 1,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       dut_o,
  output logic [1:0]       dut_a,
  output logic [1:0]       dut_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [FF_W-1:0]  first_fail,
  output logic [2:0]       dbg_state
);

  state_t            state_q, state_d;
  logic [1:0]        dut_a_q, dut_a_d;
  logic [1:0]        dut_b_q, dut_b_d;
  logic [SC_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;
  logic [FF_W-1:0]   first_fail_q, first_fail_d;
  logic              vg_clear, vg_step, vg_last;
  logic [VEC_W-1:0]  vec;
  logic [1:0]        expected;
  logic              mismatch;

  two_bit_and_vec_gen #(.PASSES(PASSES)) u_vec_gen (
    .clk   (clk),
    .reset (reset),
    .clear (vg_clear),
    .step  (vg_step),
    .vec   (vec),
    .last  (vg_last)
  );

  // Compare against the operands actually on the bus, not the counter.
  assign expected = dut_a_q & dut_b_q;
  assign mismatch = (dut_o != expected);

  always_comb begin
    state_d      = state_q;
    dut_a_d      = dut_a_q;
    dut_b_d      = dut_b_q;
    settle_cnt_d = settle_cnt_q;
    err_count_d  = err_count_q;
    first_fail_d = first_fail_q;
    vg_clear     = 1'b0;
    vg_step      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_DRIVE;
          err_count_d  = '0;
          first_fail_d = '0;
          vg_clear     = 1'b1;
        end
      end
      ST_DRIVE: begin
        dut_a_d      = vec[3:2];
        dut_b_d      = vec[1:0];
        settle_cnt_d = SC_W'(SETTLE - 1);
        state_d      = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_cnt_q == '0) state_d = ST_CHECK;
        else                    settle_cnt_d = settle_cnt_q - SC_W'(1);
      end
      ST_CHECK: begin
        if (mismatch) begin
          if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
          if (err_count_q == '0) first_fail_d = pack_fail(dut_a_q, dut_b_q, dut_o);
        end
        if (vg_last) begin
          state_d = ST_DONE;
        end else begin
          vg_step = 1'b1;
          state_d = ST_DRIVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      dut_a_q      <= '0;
      dut_b_q      <= '0;
      settle_cnt_q <= '0;
      err_count_q  <= '0;
      first_fail_q <= '0;
    end else begin
      state_q      <= state_d;
      dut_a_q      <= dut_a_d;
      dut_b_q      <= dut_b_d;
      settle_cnt_q <= settle_cnt_d;
      err_count_q  <= err_count_d;
      first_fail_q <= first_fail_d;
    end
  end

  assign dut_a      = dut_a_q;
  assign dut_b      = dut_b_q;
  assign busy       = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) || (state_q == ST_CHECK);
  assign done       = (state_q == ST_DONE);
  assign pass       = done && (err_count_q == '0);
  assign err_count  = err_count_q;
  assign first_fail = first_fail_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/two_bit_and_driver.md
Name: two_bit_and_driver

Overview:
- Stimulus/response end of the 2-bit AND interface: drives the a and b operand buses into a two_bit_and instance and samples its o result.
- Sweeps all 16 {a,b} operand pairs per pass and compares o against the expected a & b.
- Reports pass/fail, an error count and the first failing vector.
- Sits in the direction systest harness, wired port-to-port to the AND under test.

Parameters:
- SETTLE, default 1: cycles between driving an operand pair and sampling o (legal range 1..15).
- PASSES, default 1: number of full 16-vector sweeps per run (legal range 1..15).
- ERR_W, default 8: width of the error counter; the counter saturates at 2^ERR_W-1.

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  one-cycle request to begin a run; sampled only in IDLE or DONE.
- dut_o  input  2  result bus from the AND under test.
- dut_a  output  2  operand a driven to the AND under test; registered.
- dut_b  output  2  operand b driven to the AND under test; registered.
- busy  output  1  high from the cycle after start is accepted until the run ends.
- done  output  1  high in DONE; held until the next accepted start or reset.
- pass  output  1  valid while done=1; 1 means err_count==0.
- err_count  output  ERR_W  number of mismatching samples, saturating.
- first_fail  output  6  {a[1:0],b[1:0],o[1:0]} of the first mismatch; 0 if none.

Behaviour:
- Reset values: dut_a=0, dut_b=0, busy=0, done=0, pass=0, err_count=0, first_fail=0; FSM goes to IDLE, vec=0, pass_cnt=0, settle_cnt=0.
- Reset asserted mid-run aborts the run with no report; the next start begins a fresh run.
- State vec[3:0] holds the current pair; dut_a=vec[3:2], dut_b=vec[1:0]. Expected value is dut_a & dut_b, computed in 2-bit width.
- FSM states:
  - IDLE: start=1 → DRIVE; clear err_count and first_fail; vec=0; pass_cnt=0.
  - DRIVE (1 cycle): register dut_a/dut_b from vec; load settle_cnt=SETTLE-1 → SETTLE.
  - SETTLE: decrement settle_cnt each cycle; when settle_cnt==0 → CHECK.
  - CHECK (1 cycle):
    - If dut_o != expected: err_count+1 (saturating); if this is the first error, capture first_fail.
    - If vec==15: if pass_cnt==PASSES-1 → DONE, else pass_cnt+1, vec wraps to 0 → DRIVE.
    - Otherwise vec+1 → DRIVE.
  - DONE: done=1, pass=(err_count==0); start=1 → same actions as IDLE start.
- busy=1 in DRIVE, SETTLE and CHECK.
- start is ignored while busy; there is no queueing.
- Latency: with SETTLE=1 a run takes exactly 1 + 48·PASSES cycles from the start edge to done rising: one IDLE cycle plus 3 cycles per vector.
- dut_a/dut_b hold their last values (3,3) in DONE; they return to 0 only on reset.
- err_count and first_fail are frozen in DONE and readable until the next start.
- Saturation: once err_count reaches all-ones it stays there; pass remains 0.

Decomposition:
- Shared constants include file holds:
  - state encodings: IDLE=0, DRIVE=1, SETTLE=2, CHECK=3, DONE=4 (3-bit);
  - NUM_VEC=16;
  - the first_fail field offsets.
- One natural sub-module, two_bit_and_vec_gen:
  - contains the vec and pass_cnt counters;
  - inputs clear and step; outputs vec and last (vec==15 and final pass).
- FSM, compare and reporting logic stay in the top module.

Test Plan:
- Correct DUT (o=a&b), SETTLE=1, PASSES=1, start pulse at cycle 5 → done rises at cycle 54, pass=1, err_count=0, first_fail=0, dut_a=3, dut_b=3.
- DUT with o[1] stuck at 1 → err_count=12 (expected o[1]=0 in 12 of 16 vectors), pass=0, first_fail={00,00,10}=6'b000010.
- Stuck-at-1 DUT, PASSES=3, ERR_W=5 → err_count=31 (36 errors, saturated), pass=0.
- Reset asserted in the middle of SETTLE of vec=7 → all outputs return to their reset values asynchronously, before the next edge; a new start gives a clean 49-cycle run with pass=1.
- start held high across a whole run, SETTLE=3 → no restart while busy; vectors are spaced 5 cycles apart; done pulses for one cycle and the run restarts the following cycle with err_count cleared.
- O wrong only for a=2, b=3 (o=0) → err_count=1, first_fail=6'b101100.
